// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: bus geometry,
// the hard-wired zero register index and the controller state encoding.
package regfile_access_ctrl_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 31;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } accessStateT;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for the mini register file: zero-sweeps the file
// after reset, then serves write commands and single-outstanding read pairs.
module regfile_access_ctrl #(
  parameter int DATA_WIDTH    = regfile_access_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH    = regfile_access_ctrl_pkg::ADDR_WIDTH,
  parameter int ZERO_REG      = regfile_access_ctrl_pkg::ZERO_REG,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  Clk,
  input  logic                  ResetL,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [ADDR_WIDTH-1:0] CmdRA,
  input  logic [ADDR_WIDTH-1:0] CmdRB,
  input  logic [ADDR_WIDTH-1:0] CmdRW,
  input  logic [DATA_WIDTH-1:0] CmdData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspA,
  output logic [DATA_WIDTH-1:0] RspB,
  output logic                  InitDone,
  output logic [ADDR_WIDTH-1:0] RA,
  output logic [ADDR_WIDTH-1:0] RB,
  output logic [ADDR_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0] BusW,
  output logic                  RegWr,
  input  logic [DATA_WIDTH-1:0] BusA,
  input  logic [DATA_WIDTH-1:0] BusB
);
  import regfile_access_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  accessStateT           state, stateNext;
  logic [ADDR_WIDTH-1:0] sweepCnt, sweepCntNext;
  logic                  cmdReadyNext, rspValidNext, initDoneNext, regWrNext;
  logic [DATA_WIDTH-1:0] rspANext, rspBNext, busWNext;
  logic [ADDR_WIDTH-1:0] raNext, rbNext, rwNext;
  logic                  cmdAccept, rspAccept;

  // Every output is a flop; async reset also kills RegWr so no falling-edge
  // write can slip into the register file once reset is seen.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state    <= INIT_ON_RESET ? INIT : IDLE;
      sweepCnt <= '0;
      CmdReady <= 1'b0;
      RspValid <= 1'b0;
      RspA     <= '0;
      RspB     <= '0;
      InitDone <= 1'b0;
      RA       <= '0;
      RB       <= '0;
      RW       <= '0;
      BusW     <= '0;
      RegWr    <= 1'b0;
    end else begin
      state    <= stateNext;
      sweepCnt <= sweepCntNext;
      CmdReady <= cmdReadyNext;
      RspValid <= rspValidNext;
      RspA     <= rspANext;
      RspB     <= rspBNext;
      InitDone <= initDoneNext;
      RA       <= raNext;
      RB       <= rbNext;
      RW       <= rwNext;
      BusW     <= busWNext;
      RegWr    <= regWrNext;
    end
  end

  // Next-state and next-output logic; RegWr defaults low so each write
  // command produces exactly one write-enable cycle.
  always_comb begin
    stateNext    = state;
    sweepCntNext = sweepCnt;
    cmdReadyNext = CmdReady;
    rspValidNext = RspValid;
    rspANext     = RspA;
    rspBNext     = RspB;
    initDoneNext = InitDone;
    raNext       = RA;
    rbNext       = RB;
    rwNext       = RW;
    busWNext     = BusW;
    regWrNext    = 1'b0;
    cmdAccept    = CmdValid && CmdReady;
    rspAccept    = RspValid && RspReady;

    case (state)
      INIT: begin
        cmdReadyNext = 1'b0;
        // The sweep covers every index below the zero register.
        if (sweepCnt == ZERO_IDX) begin
          stateNext    = IDLE;
          initDoneNext = 1'b1;
          cmdReadyNext = 1'b1;
        end else begin
          rwNext       = sweepCnt;
          busWNext     = '0;
          regWrNext    = 1'b1;
          sweepCntNext = sweepCnt + ADDR_WIDTH'(1);
        end
      end

      IDLE: begin
        cmdReadyNext = 1'b1;
        initDoneNext = 1'b1;
        if (cmdAccept) begin
          if (CmdWrite) begin
            if (CmdRW != ZERO_IDX) begin
              rwNext    = CmdRW;
              busWNext  = CmdData;
              regWrNext = 1'b1;
            end
          end else begin
            raNext       = CmdRA;
            rbNext       = CmdRB;
            cmdReadyNext = 1'b0;
            stateNext    = READ;
          end
        end
      end

      READ: begin
        cmdReadyNext = 1'b0;
        rspANext     = BusA;
        rspBNext     = BusB;
        rspValidNext = 1'b1;
        stateNext    = RESP;
      end

      RESP: begin
        cmdReadyNext = 1'b0;
        if (rspAccept) begin
          rspValidNext = 1'b0;
          cmdReadyNext = 1'b1;
          stateNext    = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl paired with a behavioural
// falling-edge register file; table-driven vectors plus corner sequences.
module tb_regfile_access_ctrl;

  typedef struct {
    logic        isWrite;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] data;
    logic [63:0] expA;
    logic [63:0] expB;
  } vecT;

  logic        Clk = 1'b0;
  logic        ResetL;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrite;
  logic [4:0]  CmdRA;
  logic [4:0]  CmdRB;
  logic [4:0]  CmdRW;
  logic [63:0] CmdData;
  logic        RspValid;
  logic        RspReady;
  logic [63:0] RspA;
  logic [63:0] RspB;
  logic        InitDone;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [63:0] BusA;
  logic [63:0] BusB;

  logic [63:0] rfMem [32];
  logic        rfSeeded = 1'b0;
  int          checks = 0;
  int          failures = 0;
  vecT         vecs [9];

  always #5 Clk = ~Clk;

  regfile_access_ctrl dut (
    .Clk      (Clk),
    .ResetL   (ResetL),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdWrite (CmdWrite),
    .CmdRA    (CmdRA),
    .CmdRB    (CmdRB),
    .CmdRW    (CmdRW),
    .CmdData  (CmdData),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspA     (RspA),
    .RspB     (RspB),
    .InitDone (InitDone),
    .RA       (RA),
    .RB       (RB),
    .RW       (RW),
    .BusW     (BusW),
    .RegWr    (RegWr),
    .BusA     (BusA),
    .BusB     (BusB)
  );

  // Register file model: garbage at power-up, commits on the falling edge,
  // index 31 reads as zero and ignores writes.
  always @(negedge Clk) begin
    if (!rfSeeded) begin
      for (int i = 0; i < 32; i++) rfMem[i] = 64'hBADC_0DE0_0000_0000 | 64'(i);
      rfSeeded = 1'b1;
    end
    if (RegWr && RW != 5'd31) rfMem[RW] = BusW;
  end

  assign BusA = (RA == 5'd31) ? 64'd0 : rfMem[RA];
  assign BusB = (RB == 5'd31) ? 64'd0 : rfMem[RB];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents one command from a negedge and returns at the negedge after acceptance.
  task automatic applyStimulus(input logic w, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw, input logic [63:0] data);
    int n;
    CmdValid = 1'b1;
    CmdWrite = w;
    CmdRA    = ra;
    CmdRB    = rb;
    CmdRW    = rw;
    CmdData  = data;
    n = 0;
    while (!CmdReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("cmdReadyWait", 64'(CmdReady), 64'd1);
    @(negedge Clk);
    CmdValid = 1'b0;
  endtask

  task automatic doWrite(input string name, input logic [4:0] rw, input logic [63:0] data,
                         input logic expWr);
    applyStimulus(1'b1, 5'd0, 5'd0, rw, data);
    checkOutput($sformatf("%s.regWr", name), 64'(RegWr), 64'(expWr));
    if (expWr) begin
      checkOutput($sformatf("%s.rw", name), 64'(RW), 64'(rw));
      checkOutput($sformatf("%s.busW", name), BusW, data);
    end
  endtask

  task automatic doRead(input string name, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [63:0] expA, input logic [63:0] expB);
    applyStimulus(1'b0, ra, rb, 5'd0, 64'd0);
    checkOutput($sformatf("%s.rspValidEarly", name), 64'(RspValid), 64'd0);
    @(negedge Clk);
    checkOutput($sformatf("%s.rspValid", name), 64'(RspValid), 64'd1);
    checkOutput($sformatf("%s.rspA", name), RspA, expA);
    checkOutput($sformatf("%s.rspB", name), RspB, expB);
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    checkOutput($sformatf("%s.rspDone", name), 64'(RspValid), 64'd0);
    checkOutput($sformatf("%s.cmdReadyAfter", name), 64'(CmdReady), 64'd1);
  endtask

  // Expects ResetL to have just been released at a negedge.
  task automatic checkSweep(input string name);
    for (int i = 0; i < 31; i++) begin
      @(negedge Clk);
      checkOutput($sformatf("%s.regWr%0d", name, i), 64'(RegWr), 64'd1);
      checkOutput($sformatf("%s.rw%0d", name, i), 64'(RW), 64'(i));
      checkOutput($sformatf("%s.busW%0d", name, i), BusW, 64'd0);
      checkOutput($sformatf("%s.initDone%0d", name, i), 64'(InitDone), 64'd0);
      checkOutput($sformatf("%s.cmdReady%0d", name, i), 64'(CmdReady), 64'd0);
    end
    @(negedge Clk);
    checkOutput($sformatf("%s.initDoneEnd", name), 64'(InitDone), 64'd1);
    checkOutput($sformatf("%s.cmdReadyEnd", name), 64'(CmdReady), 64'd1);
    checkOutput($sformatf("%s.regWrEnd", name), 64'(RegWr), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  5'd30, 5'd0,  64'd0,                  64'd0,                  64'd0};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd5,  64'h0123_4567_89AB_CDEF, 64'd0,                  64'd0};
    vecs[2] = '{1'b0, 5'd5,  5'd31, 5'd0,  64'd0,                  64'h0123_4567_89AB_CDEF, 64'd0};
    vecs[3] = '{1'b1, 5'd0,  5'd0,  5'd3,  64'hDEAD_BEEF_0000_0003, 64'd0,                  64'd0};
    vecs[4] = '{1'b1, 5'd0,  5'd0,  5'd4,  64'h0000_0000_0000_0444, 64'd0,                  64'd0};
    vecs[5] = '{1'b0, 5'd3,  5'd4,  5'd0,  64'd0,                  64'hDEAD_BEEF_0000_0003, 64'h0000_0000_0000_0444};
    vecs[6] = '{1'b1, 5'd0,  5'd0,  5'd30, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0,                  64'd0};
    vecs[7] = '{1'b0, 5'd30, 5'd5,  5'd0,  64'd0,                  64'hA5A5_A5A5_5A5A_5A5A, 64'h0123_4567_89AB_CDEF};
    vecs[8] = '{1'b0, 5'd0,  5'd31, 5'd0,  64'd0,                  64'd0,                  64'd0};

    ResetL   = 1'b0;
    CmdValid = 1'b0;
    CmdWrite = 1'b0;
    CmdRA    = 5'd0;
    CmdRB    = 5'd0;
    CmdRW    = 5'd0;
    CmdData  = 64'd0;
    RspReady = 1'b0;
    repeat (2) @(negedge Clk);

    checkOutput("rst.cmdReady", 64'(CmdReady), 64'd0);
    checkOutput("rst.rspValid", 64'(RspValid), 64'd0);
    checkOutput("rst.rspA", RspA, 64'd0);
    checkOutput("rst.rspB", RspB, 64'd0);
    checkOutput("rst.initDone", 64'(InitDone), 64'd0);
    checkOutput("rst.ra", 64'(RA), 64'd0);
    checkOutput("rst.rb", 64'(RB), 64'd0);
    checkOutput("rst.rw", 64'(RW), 64'd0);
    checkOutput("rst.busW", BusW, 64'd0);
    checkOutput("rst.regWr", 64'(RegWr), 64'd0);

    ResetL = 1'b1;
    checkSweep("sweep");

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].isWrite)
        doWrite($sformatf("vec%0d", v), vecs[v].rw, vecs[v].data, 1'b1);
      else
        doRead($sformatf("vec%0d", v), vecs[v].ra, vecs[v].rb, vecs[v].expA, vecs[v].expB);
    end

    // Writes to the zero register are dropped.
    doWrite("zeroWr", 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge Clk);
    checkOutput("zeroWr.regWrLater", 64'(RegWr), 64'd0);
    doRead("zeroRd", 5'd31, 5'd31, 64'd0, 64'd0);

    // Response stall: outputs hold and a pending write is refused.
    applyStimulus(1'b0, 5'd3, 5'd4, 5'd0, 64'd0);
    @(negedge Clk);
    checkOutput("stall.rspValid", 64'(RspValid), 64'd1);
    CmdValid = 1'b1;
    CmdWrite = 1'b1;
    CmdRW    = 5'd7;
    CmdData  = 64'h7777_7777_7777_7777;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      checkOutput($sformatf("stall.rspValid%0d", c), 64'(RspValid), 64'd1);
      checkOutput($sformatf("stall.rspA%0d", c), RspA, 64'hDEAD_BEEF_0000_0003);
      checkOutput($sformatf("stall.rspB%0d", c), RspB, 64'h0000_0000_0000_0444);
      checkOutput($sformatf("stall.cmdReady%0d", c), 64'(CmdReady), 64'd0);
      checkOutput($sformatf("stall.regWr%0d", c), 64'(RegWr), 64'd0);
    end
    CmdValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    checkOutput("stall.rspDone", 64'(RspValid), 64'd0);
    checkOutput("stall.cmdReadyAfter", 64'(CmdReady), 64'd1);

    // Back-to-back writes: one RegWr pulse per cycle, four in a row.
    doWrite("burst1", 5'd1, 64'h1111_1111_1111_1111, 1'b1);
    doWrite("burst2", 5'd2, 64'h2222_2222_2222_2222, 1'b1);
    doWrite("burst3", 5'd3, 64'h3333_3333_3333_3333, 1'b1);
    doWrite("burst4", 5'd4, 64'h4444_4444_4444_4444, 1'b1);
    @(negedge Clk);
    checkOutput("burst.regWrEnd", 64'(RegWr), 64'd0);
    doRead("burstRd12", 5'd1, 5'd2, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
    doRead("burstRd34", 5'd3, 5'd4, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    doRead("stallRd7", 5'd7, 5'd31, 64'd0, 64'd0);

    // Reset in the middle of the sweep restarts it from index 0.
    ResetL = 1'b0;
    @(negedge Clk);
    ResetL = 1'b1;
    repeat (13) @(negedge Clk);
    checkOutput("midRst.rwBefore", 64'(RW), 64'd12);
    checkOutput("midRst.regWrBefore", 64'(RegWr), 64'd1);
    #1 ResetL = 1'b0;
    #1;
    checkOutput("midRst.regWrAsync", 64'(RegWr), 64'd0);
    checkOutput("midRst.rwAsync", 64'(RW), 64'd0);
    @(negedge Clk);
    checkOutput("midRst.regWrHeld", 64'(RegWr), 64'd0);
    ResetL = 1'b1;
    checkSweep("resweep");
    doRead("postSweep", 5'd30, 5'd5, 64'd0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Initiator-side controller for the 32×64 mini register file: owns its RA/RB/RW/BusW/RegWr pins, accepts read and write commands over a valid/ready interface, and returns read data over a valid/ready response channel. After reset it sweeps registers 0–30 to zero, so the file never exposes X values. It sits between datapath or test logic and the register file and runs on the rising edge. The register file itself writes on the falling edge, which makes back-to-back write→read of the same register safe.

## Interface
- DATA_WIDTH, 64, register/bus width
- ADDR_WIDTH, 5, register index width
- ZERO_REG, 31, hard-wired zero register; never written
- INIT_ON_RESET, 1, 1 = zero-sweep after reset; 0 = go straight to IDLE

- Clk  in  1  clock, rising edge
- ResetL  in  1  asynchronous, active-low reset
- CmdValid  in  1  command present
- CmdReady  out  1  command accepted when CmdValid&&CmdReady at a rising edge
- CmdWrite  in  1  1 = write, 0 = read pair
- CmdRA, CmdRB  in  ADDR_WIDTH  read indices
- CmdRW  in  ADDR_WIDTH  write index
- CmdData  in  DATA_WIDTH  write data
- RspValid  out  1  read response present
- RspReady  in  1  response consumed when RspValid&&RspReady at a rising edge
- RspA, RspB  out  DATA_WIDTH  read data
- InitDone  out  1  high once the zero-sweep is complete
- RA, RB  out  ADDR_WIDTH  to register file read ports
- RW  out  ADDR_WIDTH  to register file write index
- BusW  out  DATA_WIDTH  to register file write data
- RegWr  out  1  to register file write enable
- BusA, BusB  in  DATA_WIDTH  from register file read ports

## Operation
- Every output is registered.
- Reset values: CmdReady=0, RspValid=0, RspA=RspB=0, InitDone=0, RA=RB=RW=0, BusW=0, RegWr=0.
- **INIT state** (only when INIT_ON_RESET=1):
  - Sweep counter runs 0..30. Each cycle: RW=counter, BusW=0, RegWr=1.
  - After index 30, go to IDLE: RegWr=0, InitDone=1. InitDone then stays high until the next reset.
  - CmdReady=0 throughout INIT.
- **IDLE state**: CmdReady=1.
  - Accepted write:
    - If CmdRW≠ZERO_REG: next cycle RW=CmdRW, BusW=CmdData, RegWr=1 for exactly one cycle.
    - If CmdRW=ZERO_REG: the write is dropped and RegWr stays 0.
    - State stays IDLE, so back-to-back writes run at one per cycle.
  - Accepted read: RA=CmdRA, RB=CmdRB are registered. Go to READ with CmdReady=0.
- **READ state**: one cycle. At the next rising edge, BusA→RspA and BusB→RspB are captured and RspValid=1. Go to RESP.
- **RESP state**:
  - RspA, RspB and RspValid hold stable until RspReady.
  - On the handshake: RspValid=0, go to IDLE, and CmdReady=1 from the following cycle.
- No outstanding reads beyond one; a write cannot be accepted while a read is outstanding.
- A read of ZERO_REG returns the register file's contents (0). The block adds no special-casing.
- RA/RB hold their last values when not reading.

## Timing
- Write latency: command accepted at edge N → RegWr high from N to N+1 → register file commits at the falling edge inside that cycle.
- Read latency: accept at edge N → RA/RB valid after N → RspValid high after N+1. Minimum read-to-read period is 3 cycles when RspReady is held high.
- Read-after-write: write accepted at N and read of the same index accepted at N+1 → response carries the new data. The commit at N+½ precedes the capture at N+2.
- INIT length is 31 cycles. With ResetL deasserted before edge 0, InitDone=1 and CmdReady=1 after edge 31.
- ResetL asserted at any time, including mid-INIT, mid-write or during RESP:
  - All outputs go to reset values immediately, with RegWr forced to 0 asynchronously so no pending falling-edge write occurs.
  - Any pending response is discarded.
  - INIT restarts from index 0 after ResetL deasserts.

## Structure
- Shared package: state encoding (INIT, IDLE, READ, RESP), ZERO_REG, DATA_WIDTH, ADDR_WIDTH.
- Single module, no sub-modules. The sweep counter is inline.
- The verification top instantiates this block together with the existing register file.

## Test plan
- Reset with INIT_ON_RESET=1 → RegWr=1 for 31 consecutive cycles with RW=0..30 and BusW=0; InitDone=1 and CmdReady=1 after edge 31; then read (0,30) → RspA=RspB=0.
- Write R5=0x0123_4567_89AB_CDEF, then read (5,31) on the next cycle → RspA=0x0123456789ABCDEF, RspB=0.
- Write to index 31 with CmdData=0xFFFF… → RegWr never asserts; a later read of 31 returns 0.
- Read (3,4) with RspReady held low for 10 cycles → RspValid stays high, RspA/RspB stay stable, CmdReady=0 throughout; raising RspReady → handshake, CmdReady=1 the next cycle.
- Four back-to-back writes to R1–R4 → RegWr high for 4 consecutive cycles; reads then return the written values.
- Assert ResetL low at sweep index 12 → RegWr drops to 0 immediately; after release the sweep restarts at RW=0 and InitDone is delayed the full 31 cycles.
